// File: rtl/uart_pkg.sv
// +-------------------------------------------------------------------+
// | uart_pkg : shared state encoding and counter widths for UART RX  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  function automatic int calc_tick_w(input int osr);
    return $clog2(osr);
  endfunction

  function automatic int calc_bit_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  localparam int DEF_OSR       = 16;
  localparam int DEF_DATA_BITS = 8;
  localparam int TICK_W        = calc_tick_w(DEF_OSR);
  localparam int BIT_W         = calc_bit_w(DEF_DATA_BITS);

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// +-------------------------------------------------------------------+
// | uart_bit_timer : i_en-qualified modulo-OSR tick counter           |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OSR = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int C_TICK_W = calc_tick_w(OSR);

  logic [C_TICK_W-1:0] r_cnt;
  logic                w_last;

  assign w_last = (r_cnt == C_TICK_W'(OSR - 1));
  assign o_tick = i_en & w_last & ~i_clr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_deser.sv
// +-------------------------------------------------------------------+
// | uart_rx_deser : mid-bit sampler and LSB-first deserializer        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_rx,
  input  logic                 i_found,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int C_BIT_W = calc_bit_w(DATA_BITS);

  rx_state_t              r_state;
  logic [C_BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_busy;
  logic                   w_tick;
  logic                   w_clr;

  // Holding the timer cleared in IDLE keeps the found edge from counting as a tick.
  assign w_clr = (r_state == ST_IDLE);

  uart_bit_timer #(
    .OSR (OSR)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_found) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift   <= {i_rx, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == C_BIT_W'(DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (i_rx) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
// +-------------------------------------------------------------------+
// | tb_uart_rx_deser : randomized self-checking bench for uart_rx_deser|
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_deser;

  localparam int OSR         = 16;
  localparam int DB          = 8;
  localparam int FRAME_TICKS = (DB + 1) * OSR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rx;
  logic          found;
  logic [DB-1:0] data;
  logic          valid;
  logic          ferr;
  logic          busy;

  int            checks   = 0;
  int            failures = 0;
  logic [DB-1:0] last_good;

  always #5 clk = ~clk;

  uart_rx_deser #(
    .OSR       (OSR),
    .DATA_BITS (DB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_en        (en),
    .i_rx        (rx),
    .i_found     (found),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line level n ticks after the start-bit midpoint; bit edges sit half a period off the midpoints.
  function automatic logic line_at(input int n, input logic [DB-1:0] d, input bit stop_ok);
    int p;
    p = (n + OSR / 2) / OSR;
    if (p == 0)  return 1'b0;
    if (p <= DB) return d[p-1];
    return stop_ok;
  endfunction

  task automatic idle_ticks(input int nt, input int per);
    int k;
    int cyc;
    bit pulse;
    k = 0; cyc = 0; pulse = 0;
    rx = 1'b1; found = 1'b0;
    while (k < nt) begin
      cyc++;
      en = (cyc % per == 0);
      @(posedge clk); @(negedge clk);
      if (en) k++;
      if (valid || ferr) pulse = 1;
    end
    en = 1'b0;
    check_eq("idle_no_pulse", 32'(pulse), 32'd0);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input int per,
                            input int spur1, input int spur2, input int abort_at);
    int n;
    int cyc;
    bit early;
    bit busy_ok;
    n = 0; cyc = 0; early = 0; busy_ok = 1;
    found = 1'b1; rx = 1'b0; en = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    found = 1'b0;
    while (n < FRAME_TICKS) begin
      if (abort_at != 0 && n == abort_at) begin
        rst_n = 1'b0; en = 1'b0; rx = 1'b1;
        #1;
        check_eq("abort_data",  32'(data),  32'd0);
        check_eq("abort_valid", 32'(valid), 32'd0);
        check_eq("abort_ferr",  32'(ferr),  32'd0);
        check_eq("abort_busy",  32'(busy),  32'd0);
        last_good = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_ticks(3 * OSR, 1);
        check_eq("abort_after_data", 32'(data), 32'(last_good));
        return;
      end
      cyc++;
      en = (cyc % per == 0);
      found = 1'b0;
      if (en) begin
        rx    = line_at(n + 1, d, stop_ok);
        found = (n + 1 == spur1) || (n + 1 == spur2);
      end
      @(posedge clk); @(negedge clk);
      if (en) n++;
      if (n < FRAME_TICKS) begin
        if (valid || ferr) early = 1;
        if (!busy) busy_ok = 0;
      end
    end
    en = 1'b0; rx = 1'b1; found = 1'b0;
    check_eq("no_early_pulse", 32'(early),   32'd0);
    check_eq("busy_in_frame",  32'(busy_ok), 32'd1);
    check_eq("valid_pulse",    32'(valid),   32'(stop_ok));
    check_eq("ferr_pulse",     32'(ferr),    32'(!stop_ok));
    if (stop_ok) last_good = d;
    check_eq("data",           32'(data),    32'(last_good));
    @(posedge clk); @(negedge clk);
    check_eq("valid_one_cycle", 32'(valid), 32'd0);
    check_eq("ferr_one_cycle",  32'(ferr),  32'd0);
    check_eq("busy_dropped",    32'(busy),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rx = 1'b1; found = 1'b0; last_good = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_data",  32'(data),  32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_ferr",  32'(ferr),  32'd0);
    check_eq("rst_busy",  32'(busy),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(8'hA5, 1'b1, 1, 0, 0, 0);
    send_frame(8'h3C, 1'b0, 1, 0, 0, 0);
    idle_ticks(4, 1);
    send_frame(8'h81, 1'b1, 3, 0, 0, 0);
    idle_ticks(4, 1);
    send_frame(8'h00, 1'b1, 1, 0, 0, 0);
    idle_ticks(7, 1);
    send_frame(8'hFF, 1'b1, 1, 0, 0, 0);
    idle_ticks(4, 1);
    send_frame(8'h5A, 1'b1, 1, 20, 100, 0);
    idle_ticks(4, 1);
    send_frame(8'hC3, 1'b1, 1, 0, 0, 70);
    send_frame(8'h12, 1'b1, 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      idle_ticks(int'($urandom_range(1, 10)), 1);
      send_frame(DB'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, FRAME_TICKS - 1)), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
